// File: rtl/reduction_array_stream.sv
// Streaming per-channel matrix reducer: one column per beat, valid/ready both sides.
// Build option: define SATURATE_EN to clamp results and drive overflow; default wraps.
module reduction_array_stream #(
   parameter int N_CH       = 10,
   parameter int DATA_WIDTH = 16,
   parameter int COL_HEIGHT = 2,
   parameter int N_COLS     = 4,
   parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(COL_HEIGHT * N_COLS) + 1
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic                                          in_last,
   input  logic [N_CH-1:0][COL_HEIGHT-1:0][DATA_WIDTH-1:0] column,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [N_CH-1:0][DATA_WIDTH-1:0]               sum,
   output logic [N_CH-1:0]                               overflow
);

   localparam int CNT_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(N_COLS - 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t state_q, state_d;

   logic signed [ACC_WIDTH-1:0] acc_q  [N_CH];
   logic signed [ACC_WIDTH-1:0] acc_n  [N_CH];
   logic signed [ACC_WIDTH-1:0] colsum [N_CH];

   logic [CNT_W-1:0]               col_cnt_q;
   logic [N_CH-1:0][DATA_WIDTH-1:0] sum_q, sum_d;
   logic                           beat, final_beat, drain;

`ifdef SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] SMAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SMIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic [N_CH-1:0] ovf_q, ovf_d;

   assign overflow = ovf_q;
`else
   assign overflow = '0;
`endif

   assign out_valid  = (state_q == HOLD);
   assign in_ready   = !out_valid || out_ready;
   assign beat       = in_valid && in_ready;
   assign drain      = out_valid && out_ready;
   assign final_beat = beat && (in_last || col_cnt_q == LAST_COL);
   assign sum        = sum_q;

   always_comb begin
      state_d = state_q;
      if (final_beat) begin
         state_d = HOLD;
      end else if (drain) begin
         state_d = ACCUM;
      end
   end

   // Accumulator is wide enough that neither colsum nor acc_n can wrap.
   always_comb begin
      for (int ch = 0; ch < N_CH; ch++) begin
         colsum[ch] = '0;
         for (int r = 0; r < COL_HEIGHT; r++) begin
            colsum[ch] = colsum[ch] +
               {{(ACC_WIDTH-DATA_WIDTH){column[ch][r][DATA_WIDTH-1]}},
                column[ch][r]};
         end
      end
   end

   always_comb begin
      sum_d = '0;
`ifdef SATURATE_EN
      ovf_d = '0;
`endif
      for (int ch = 0; ch < N_CH; ch++) begin
         acc_n[ch] = acc_q[ch] + colsum[ch];
`ifdef SATURATE_EN
         if (acc_n[ch] > SMAX) begin
            sum_d[ch] = SMAX[DATA_WIDTH-1:0];
            ovf_d[ch] = 1'b1;
         end else if (acc_n[ch] < SMIN) begin
            sum_d[ch] = SMIN[DATA_WIDTH-1:0];
            ovf_d[ch] = 1'b1;
         end else begin
            sum_d[ch] = acc_n[ch][DATA_WIDTH-1:0];
         end
`else
         sum_d[ch] = acc_n[ch][DATA_WIDTH-1:0];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ACCUM;
         col_cnt_q <= '0;
         sum_q     <= '0;
`ifdef SATURATE_EN
         ovf_q     <= '0;
`endif
         for (int ch = 0; ch < N_CH; ch++) begin
            acc_q[ch] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (beat) begin
            col_cnt_q <= final_beat ? '0 : col_cnt_q + 1'b1;
            for (int ch = 0; ch < N_CH; ch++) begin
               acc_q[ch] <= final_beat ? '0 : acc_n[ch];
            end
         end
         // Next matrix may finish in the same cycle the old result drains.
         if (final_beat) begin
            sum_q <= sum_d;
`ifdef SATURATE_EN
            ovf_q <= ovf_d;
`endif
         end
      end
   end

endmodule
